// File: rtl/iter_shifter.sv
// ---------------------------------------------------------------------------
// iter_shifter
//   Multi-cycle shift unit for the RV32 execute stage. Performs SLL, SRL, SRA
//   and ROL on an N-bit operand, moving at most STEP bits per clock so the
//   datapath is a small STEP-wide mux instead of a full barrel shifter.
//
//   Parameters
//     N     operand/result width (power of two, >= 4)
//     STEP  max bits shifted per cycle (power of two, 1 <= STEP <= N/2)
//
//   Ports
//     clk     system clock, rising edge
//     rst_n   asynchronous active-low reset
//     start   request, only looked at while idle
//     a       operand, captured on an accepted start
//     shamt   shift amount 0..N-1, captured on an accepted start
//     mode    00 SLL, 01 SRL, 10 SRA, 11 ROL, captured on an accepted start
//     busy    high while an operation is in flight (SHIFT or DONE)
//     done    one-cycle pulse, result valid in that cycle
//     result  working register; held until the next accepted start
//
//   Timing: start accepted at edge T -> max(1, ceil(shamt/STEP)) SHIFT cycles
//   -> one DONE cycle -> IDLE. A shamt of 0 still spends one SHIFT cycle.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// iter_shift_tap
//   Fixed-distance shift of din by AMT bits (1 <= AMT < N) for the selected
//   mode. One tap per possible step distance; the top picks one per cycle.
//
//   Ports
//     mode  operation (encoding as in iter_shifter)
//     din   current working value
//     dout  din shifted by AMT
// ---------------------------------------------------------------------------
module iter_shift_tap #(
   parameter int N   = 32,
   parameter int AMT = 1
) (
   input  logic [1:0]   mode,
   input  logic [N-1:0] din,
   output logic [N-1:0] dout
);

   always_comb begin
      case (mode)
         2'b00:   dout = {din[N-1-AMT:0], {AMT{1'b0}}};
         2'b01:   dout = {{AMT{1'b0}}, din[N-1:AMT]};
         // Current MSB is the original sign: every earlier step preserved it.
         2'b10:   dout = {{AMT{din[N-1]}}, din[N-1:AMT]};
         default: dout = {din[N-1-AMT:0], din[N-1:N-AMT]};
      endcase
   end

endmodule

module iter_shifter #(
   parameter int N    = 32,
   parameter int STEP = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [N-1:0]         a,
   input  logic [$clog2(N)-1:0] shamt,
   input  logic [1:0]           mode,
   output logic                 busy,
   output logic                 done,
   output logic [N-1:0]         result
);

   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      M_SLL = 2'b00,
      M_SRL = 2'b01,
      M_SRA = 2'b10,
      M_ROL = 2'b11
   } mode_t;

   state_t            state, state_nxt;
   logic   [N-1:0]    sreg;
   logic   [N-1:0]    sreg_step;
   logic   [CW-1:0]   count;
   logic   [CW-1:0]   k;
   mode_t             mode_q;

   // One candidate per step distance; cand[0] is the unshifted value.
   logic [STEP:0][N-1:0] cand;

   assign cand[0] = sreg;

   for (genvar j = 1; j <= STEP; j++) begin : g_tap
      iter_shift_tap #(
         .N   (N),
         .AMT (j)
      ) u_tap (
         .mode (mode_q),
         .din  (sreg),
         .dout (cand[j])
      );
   end

   // k = min(count, STEP); the final partial step is therefore exact.
   // STEP <= N/2 always fits in CW bits.
   assign k = (count < CW'(STEP)) ? count : CW'(STEP);

   always_comb begin
      sreg_step = cand[0];
      for (int j = 1; j <= STEP; j++) begin
         if (k == CW'(j)) sreg_step = cand[j];
      end
   end

   // ---------------------------------------------------------------------
   // FSM: state register. busy/done are flops loaded from the next state so
   // they switch together with the state and have no input-to-output path.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != S_IDLE);
         done  <= (state_nxt == S_DONE);
      end
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_SHIFT;
         // count==0 on entry (shamt=0) gives k=0 and exits after one cycle.
         S_SHIFT: if (count == k) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath: working register, remaining count, latched operation.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg   <= '0;
         count  <= '0;
         mode_q <= M_SLL;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  sreg   <= a;
                  count  <= shamt;
                  mode_q <= mode_t'(mode);
               end
            end
            S_SHIFT: begin
               sreg  <= sreg_step;
               count <= count - k;
            end
            default: ;
         endcase
      end
   end

   assign result = sreg;

endmodule
